// File: rtl/cla_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cla_pkg : shared types, defaults and geometry helpers for cla_pipe
// | rev 1.0
// +-----------------------------------------------------------------------------
package cla_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_GROUP  = 4;
    localparam int DEF_STAGES = 2;

    // Control fields that travel with every beat through the stage registers.
    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctl_t;

    function automatic bit cfg_ok(input int width, input int group, input int stages);
        return (group > 0) && (stages > 0) && (width >= group * stages) &&
               ((width % (group * stages)) == 0);
    endfunction

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int ngrp(input int width, input int group, input int stages);
        return width / (stages * group);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cla_group : GROUP-bit lookahead cell with sum and group propagate/generate
// | rev 1.0
// +-----------------------------------------------------------------------------
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Loop form of the lookahead equations; it unrolls into flat sum-of-products.
    always_comb begin
        logic c;
        logic gg;
        logic pp;
        s  = '0;
        c  = cin;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            s[i] = w_p[i] ^ c;
            c    = w_g[i] | (w_p[i] & c);
            gg   = w_g[i] | (w_p[i] & gg);
            pp   = pp & w_p[i];
        end
        p = pp;
        g = gg;
    end

endmodule
`default_nettype wire

// File: rtl/cla_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cla_pipe : pipelined carry-lookahead add/sub with valid/ready backpressure
// | rev 1.0
// +-----------------------------------------------------------------------------
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int GROUP  = DEF_GROUP,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE_W = slice_w(WIDTH, STAGES);
    localparam int NGRP    = ngrp(WIDTH, GROUP, STAGES);
    localparam int LAST    = STAGES - 1;

    if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_err
        $error("cla_pipe: WIDTH must be a non-zero multiple of GROUP*STAGES");
    end

    // a/b carry the not-yet-computed operand bits; s accumulates the finished low bits.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t             r_stg   [STAGES];
    stage_t             w_in    [STAGES];
    stage_t             w_nx    [STAGES];
    logic [SLICE_W-1:0] w_ssum  [STAGES];
    logic               w_scout [STAGES];
    logic [STAGES-1:0]  w_ready;
    logic               w_cmsb;
    logic               w_ovf;
    logic               r_ovf;
    logic               r_zero;

    always_comb begin
        w_in[0].ctl.valid = in_valid;
        w_in[0].ctl.sub   = sub_flag;
        w_in[0].ctl.carry = sub_flag;
        w_in[0].a         = src1;
        w_in[0].b         = src2;
        w_in[0].s         = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_in[k] = r_stg[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [SLICE_W-1:0] w_a_sl;
        logic [SLICE_W-1:0] w_b_sl;
        logic [SLICE_W-1:0] w_s_sl;
        logic [NGRP-1:0]    w_gp;
        logic [NGRP-1:0]    w_gg;
        logic [NGRP:0]      w_gc;

        assign w_a_sl = w_in[k].a[k*SLICE_W +: SLICE_W];
        assign w_b_sl = w_in[k].b[k*SLICE_W +: SLICE_W] ^ {SLICE_W{w_in[k].ctl.sub}};

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a   (w_a_sl[j*GROUP +: GROUP]),
                .b   (w_b_sl[j*GROUP +: GROUP]),
                .cin (w_gc[j]),
                .s   (w_s_sl[j*GROUP +: GROUP]),
                .p   (w_gp[j]),
                .g   (w_gg[j])
            );
        end

        // Second-level lookahead: every group carry straight from slice carry-in.
        always_comb begin
            logic c0;
            logic term;
            logic run;
            c0      = w_in[k].ctl.carry;
            w_gc    = '0;
            w_gc[0] = c0;
            for (int j = 0; j < NGRP; j++) begin
                term = w_gg[j];
                run  = w_gp[j];
                for (int i = j - 1; i >= 0; i--) begin
                    term = term | (run & w_gg[i]);
                    run  = run & w_gp[i];
                end
                w_gc[j+1] = term | (run & c0);
            end
        end

        assign w_ssum[k]  = w_s_sl;
        assign w_scout[k] = w_gc[NGRP];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nx[k]                         = w_in[k];
            w_nx[k].s[k*SLICE_W +: SLICE_W] = w_ssum[k];
            w_nx[k].ctl.carry               = w_scout[k];
        end
    end

    // Carry into the MSB recovered from sum ^ propagate at that bit.
    assign w_cmsb = w_ssum[LAST][SLICE_W-1] ^ w_in[LAST].a[WIDTH-1] ^
                    w_in[LAST].b[WIDTH-1] ^ w_in[LAST].ctl.sub;
    assign w_ovf  = w_cmsb ^ w_scout[LAST];

    always_comb begin
        logic acc;
        w_ready = '0;
        acc     = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            acc        = acc | ~r_stg[k].ctl.valid;
            w_ready[k] = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg[k] <= '0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    if (w_in[k].ctl.valid) begin
                        r_stg[k] <= w_nx[k];
                    end else begin
                        r_stg[k].ctl.valid <= 1'b0;
                    end
                end
            end
            if (w_ready[LAST] && w_in[LAST].ctl.valid) begin
                r_ovf  <= w_ovf;
                r_zero <= ~|w_nx[LAST].s;
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_stg[LAST].ctl.valid;
    assign sum       = r_stg[LAST].s;
    assign carry_out = r_stg[LAST].ctl.carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_cla_pipe : directed and streamed checks of cla_pipe (32/4/2 and 16/4/4)
// | rev 1.0
// +-----------------------------------------------------------------------------
module tb_cla_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, sub_flag, out_valid, out_ready;
    logic        carry_out, overflow, zero;
    logic [31:0] src1, src2, sum;

    logic        rst_n_b, in_valid_b, in_ready_b, sub_b, out_valid_b, out_ready_b;
    logic        carry_b, overflow_b, zero_b;
    logic [15:0] src1_b, src2_b, sum_b;

    int          n_checks = 0;
    int          n_err    = 0;
    int          sent, got;
    logic        acc, seen, held_ok;
    logic [63:0] held, expv;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    cla_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .sub_flag(sub_flag), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    cla_pipe #(.WIDTH(16), .GROUP(4), .STAGES(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .src1(src1_b), .src2(src2_b), .sub_flag(sub_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .sum(sum_b), .carry_out(carry_b),
        .overflow(overflow_b), .zero(zero_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {overflow, carry, zero, sum[w-1:0]}.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        logic [32:0] t;
        logic [31:0] m, bb, sm;
        logic        c, o, z;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bb = (s ? ~b : b) & m;
        t  = {1'b0, a & m} + {1'b0, bb} + {32'd0, s};
        sm = t[31:0] & m;
        c  = t[w];
        o  = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
        z  = (sm == 32'd0);
        return ({61'd0, o, c, z} << w) | {32'd0, sm};
    endfunction

    // Caller sits just after a negedge; beat is accepted at the next posedge.
    task automatic beat_a(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sb, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; src1 = a; src2 = b; sub_flag = sb;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " sum"}, sum, es);
        chk({tag, " carry"}, carry_out, ec);
        chk({tag, " overflow"}, overflow, eo);
        chk({tag, " zero"}, zero, ez);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; src1 = '0; src2 = '0; sub_flag = 0; out_ready = 1;
        rst_n_b = 0; in_valid_b = 0; src1_b = '0; src2_b = '0; sub_b = 0; out_ready_b = 1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset carry", carry_out, 0);
        chk("reset overflow", overflow, 0);
        chk("reset zero", zero, 0);
        rst_n = 1; rst_n_b = 1;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);

        beat_a("add 1+2",       32'h0000_0001, 32'h0000_0002, 0, 32'h0000_0003, 0, 0, 0);
        beat_a("add wrap",      32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0, 1);
        beat_a("add slice cin", 32'h0000_FFFF, 32'h0000_0001, 0, 32'h0001_0000, 0, 0, 0);
        beat_a("add pos ovf",   32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1, 0);
        beat_a("sub min-1",     32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1, 1, 0);
        beat_a("sub 5-7",       32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 0, 0, 0);
        beat_a("sub 7-7",       32'h0000_0007, 32'h0000_0007, 1, 32'h0000_0000, 1, 0, 1);
        @(negedge clk);

        // Backpressure: 8 beats, downstream stalled for the first 5 cycles.
        sent = 0; got = 0; seen = 0; held_ok = 0; held = '0;
        in_valid = 1; src1 = $urandom; src2 = $urandom; sub_flag = 1'($urandom);
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = (cyc >= 5);
            #1;
            if (cyc < 5) chk($sformatf("bp in_ready c%0d", cyc), in_ready, (cyc < 2));
            acc = in_valid && in_ready;
            if (acc) qa.push_back(model(32, src1, src2, sub_flag));
            if (out_valid && !out_ready) begin
                if (held_ok) chk($sformatf("bp stable c%0d", cyc),
                                 {overflow, carry_out, zero, sum}, held);
                held = {overflow, carry_out, zero, sum}; held_ok = 1;
            end
            if (seen && got < 8) chk($sformatf("bp no gap c%0d", cyc), out_valid, 1);
            if (out_valid && out_ready) begin
                chk("bp queue nonempty", (qa.size() > 0), 1);
                expv = (qa.size() > 0) ? qa.pop_front() : '0;
                chk($sformatf("bp beat %0d", got), {overflow, carry_out, zero, sum}, expv);
                got++; seen = 1;
            end
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    src1 = $urandom; src2 = $urandom; sub_flag = 1'($urandom);
                end else in_valid = 0;
            end
        end
        in_valid = 0;
        chk("bp all beats out", got, 8);

        // Reset while two beats are in flight.
        out_ready = 0;
        in_valid = 1; src1 = 32'hFFFF_FFFF; src2 = 32'h0000_0002; sub_flag = 0;
        @(negedge clk);
        src1 = 32'h1234_5678; src2 = 32'h1111_1111;
        @(negedge clk);
        in_valid = 0;
        chk("rm filled out_valid", out_valid, 1);
        chk("rm filled sum", sum, 32'h0000_0001);
        chk("rm filled carry", carry_out, 1);
        #2 rst_n = 0;
        #1;
        chk("rm async out_valid", out_valid, 0);
        chk("rm async sum", sum, 0);
        chk("rm async carry", carry_out, 0);
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rm no stale %0d", i), out_valid, 0);
        end
        beat_a("post-reset sub", 32'h0000_0010, 32'h0000_0003, 1, 32'h0000_000D, 1, 0, 0);
        @(negedge clk);

        // 16-bit, 4-slice instance: latency and carry across all slice boundaries.
        in_valid_b = 1; src1_b = 16'hFFFF; src2_b = 16'h0001; sub_b = 0;
        @(negedge clk);
        in_valid_b = 0;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("b latency early %0d", i), out_valid_b, 0);
            @(negedge clk);
        end
        chk("b latency out_valid", out_valid_b, 1);
        chk("b wrap result", {overflow_b, carry_b, zero_b, sum_b}, {1'b0, 1'b1, 1'b1, 16'h0000});
        @(negedge clk);

        // Random sweep with random downstream stalls.
        sent = 0; got = 0;
        in_valid_b = 1; src1_b = 16'h8000; src2_b = 16'h0001; sub_b = 1;
        for (int cyc = 0; cyc < 400 && got < 24; cyc++) begin
            out_ready_b = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid_b && in_ready_b;
            if (acc) qb.push_back(model(16, {16'd0, src1_b}, {16'd0, src2_b}, sub_b));
            if (out_valid_b && out_ready_b) begin
                chk("b queue nonempty", (qb.size() > 0), 1);
                expv = (qb.size() > 0) ? qb.pop_front() : '0;
                chk($sformatf("b beat %0d", got), {overflow_b, carry_b, zero_b, sum_b}, expv);
                got++;
            end
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 24) begin
                    src1_b = 16'($urandom); src2_b = 16'($urandom); sub_b = 1'($urandom);
                end else in_valid_b = 0;
            end
        end
        in_valid_b = 0;
        chk("b all beats out", got, 24);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
